// File: rtl/multiport_register_file_pkg.sv
// Shared types and default sizing for the multiport register file and its dump engine.
package multiport_register_file_pkg;

   localparam int DEFAULT_XLEN  = 32;
   localparam int DEFAULT_DEPTH = 32;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } dump_state_t;

endpackage

// File: rtl/regfile_dump_fsm.sv
// Sequencer for the debug dump: walks indices 0..DEPTH-1 under a valid/ready handshake.
module regfile_dump_fsm
   import multiport_register_file_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          dumpStart,
   input  logic          dumpReady,
   output logic          dumpValid,
   output logic          dumpLast,
   output logic [AW-1:0] dumpIndex
);

   localparam logic [AW-1:0] LAST_INDEX = AW'(DEPTH - 1);

   dump_state_t   state_reg;
   logic [AW-1:0] index_reg;
   logic          valid_reg;
   logic          last_reg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         index_reg <= '0;
         valid_reg <= 1'b0;
         last_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (dumpStart) begin
                  state_reg <= SCAN;
                  index_reg <= '0;
                  valid_reg <= 1'b1;
                  last_reg  <= 1'b0;
               end
            end
            SCAN: begin
               // Index only moves on a handshake, so a stalled beat is held intact.
               if (dumpReady) begin
                  if (index_reg == LAST_INDEX) begin
                     state_reg <= IDLE;
                     index_reg <= '0;
                     valid_reg <= 1'b0;
                     last_reg  <= 1'b0;
                  end else begin
                     index_reg <= index_reg + 1'b1;
                     last_reg  <= ((index_reg + 1'b1) == LAST_INDEX);
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               index_reg <= '0;
               valid_reg <= 1'b0;
               last_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign dumpValid = valid_reg;
   assign dumpLast  = last_reg;
   assign dumpIndex = index_reg;

endmodule

// File: rtl/multiport_register_file.sv
// Parametrised register file: N read / M write ports with write-to-read bypass,
// a busy scoreboard for pending producers, and a handshaked debug dump.
module multiport_register_file
   import multiport_register_file_pkg::*;
#(
   parameter  int XLEN      = DEFAULT_XLEN,
   parameter  int DEPTH     = DEFAULT_DEPTH,
   parameter  int NUM_READ  = 2,
   parameter  int NUM_WRITE = 1,
   parameter  bit ZERO_REG  = 1'b1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [NUM_READ*AW-1:0]    readAddress,
   output logic [NUM_READ*XLEN-1:0]  readData,
   output logic [NUM_READ-1:0]       readBusy,
   input  logic [NUM_WRITE-1:0]      writeEnable,
   input  logic [NUM_WRITE*AW-1:0]   writeAddress,
   input  logic [NUM_WRITE*XLEN-1:0] writeData,
   input  logic                      reserveEnable,
   input  logic [AW-1:0]             reserveAddress,
   input  logic                      dumpStart,
   input  logic                      dumpReady,
   output logic                      dumpValid,
   output logic [AW-1:0]             dumpIndex,
   output logic [XLEN-1:0]           dumpData,
   output logic                      dumpLast
);

   logic [XLEN-1:0]  regs_reg [DEPTH];
   logic [DEPTH-1:0] busy_reg;

   // Ports are visited in ascending order so the highest enabled port lands last.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) regs_reg[i] <= '0;
      end else begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (writeEnable[w] && !(ZERO_REG && writeAddress[w*AW +: AW] == '0))
               regs_reg[writeAddress[w*AW +: AW]] <= writeData[w*XLEN +: XLEN];
         end
      end
   end

   // Reserve is applied after the write clears so a same-address reserve keeps busy set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         busy_reg <= '0;
      end else begin
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (writeEnable[w]) busy_reg[writeAddress[w*AW +: AW]] <= 1'b0;
         end
         if (reserveEnable && !(ZERO_REG && reserveAddress == '0))
            busy_reg[reserveAddress] <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_READ; gi++) begin : g_read
         logic [AW-1:0]   addr;
         logic [XLEN-1:0] data_next;
         logic            busy_next;

         assign addr = readAddress[gi*AW +: AW];

         always_comb begin
            data_next = regs_reg[addr];
            busy_next = busy_reg[addr];
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (writeEnable[w] && writeAddress[w*AW +: AW] == addr) begin
                  data_next = writeData[w*XLEN +: XLEN];
                  busy_next = 1'b0;
               end
            end
            if (ZERO_REG && addr == '0) begin
               data_next = '0;
               busy_next = 1'b0;
            end
         end

         assign readData[gi*XLEN +: XLEN] = data_next;
         assign readBusy[gi]              = busy_next;
      end
   endgenerate

   regfile_dump_fsm #(
      .DEPTH(DEPTH)
   ) u_dump_fsm (
      .clock     (clock),
      .reset     (reset),
      .dumpStart (dumpStart),
      .dumpReady (dumpReady),
      .dumpValid (dumpValid),
      .dumpLast  (dumpLast),
      .dumpIndex (dumpIndex)
   );

   // Committed contents only: the dump never sees same-cycle bypass data.
   assign dumpData = regs_reg[dumpIndex];

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed bench for multiport_register_file with a per-cycle reference model check.
module tb_multiport_register_file;

   localparam int XLEN  = 32;
   localparam int DEPTH = 32;
   localparam int AW    = 5;
   localparam int NR    = 2;
   localparam int NW    = 2;

   logic             clock = 1'b0;
   logic             reset = 1'b1;
   logic [AW-1:0]    ra [NR];
   logic [NW-1:0]    we;
   logic [AW-1:0]    wa [NW];
   logic [XLEN-1:0]  wd [NW];
   logic             reserveEnable;
   logic [AW-1:0]    reserveAddress;
   logic             dumpStart;
   logic             dumpReady;

   logic [NR*AW-1:0]   readAddress;
   logic [NR*XLEN-1:0] readData;
   logic [NR-1:0]      readBusy;
   logic [NW*AW-1:0]   writeAddress;
   logic [NW*XLEN-1:0] writeData;
   logic               dumpValid;
   logic [AW-1:0]      dumpIndex;
   logic [XLEN-1:0]    dumpData;
   logic               dumpLast;

   assign readAddress  = {ra[1], ra[0]};
   assign writeAddress = {wa[1], wa[0]};
   assign writeData    = {wd[1], wd[0]};

   multiport_register_file #(
      .XLEN(XLEN), .DEPTH(DEPTH), .NUM_READ(NR), .NUM_WRITE(NW), .ZERO_REG(1'b1)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .readAddress    (readAddress),
      .readData       (readData),
      .readBusy       (readBusy),
      .writeEnable    (we),
      .writeAddress   (writeAddress),
      .writeData      (writeData),
      .reserveEnable  (reserveEnable),
      .reserveAddress (reserveAddress),
      .dumpStart      (dumpStart),
      .dumpReady      (dumpReady),
      .dumpValid      (dumpValid),
      .dumpIndex      (dumpIndex),
      .dumpData       (dumpData),
      .dumpLast       (dumpLast)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: architectural register contents, pending-producer set, dump progress.
   logic [XLEN-1:0] m_regs [DEPTH];
   bit              m_busy [DEPTH];
   bit              m_dump_active;
   int              m_beat;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] <= '0;
            m_busy[i] <= 1'b0;
         end
         m_dump_active <= 1'b0;
         m_beat        <= 0;
      end else begin
         for (int w = 0; w < NW; w++) begin
            if (we[w] && wa[w] != 0) m_regs[wa[w]] <= wd[w];
            if (we[w]) m_busy[wa[w]] <= 1'b0;
         end
         if (reserveEnable && reserveAddress != 0) m_busy[reserveAddress] <= 1'b1;
         if (!m_dump_active) begin
            if (dumpStart) begin
               m_dump_active <= 1'b1;
               m_beat        <= 0;
            end
         end else if (dumpReady) begin
            if (m_beat == DEPTH - 1) m_dump_active <= 1'b0;
            else                     m_beat <= m_beat + 1;
         end
      end
   end

   function automatic logic [XLEN-1:0] exp_read(input logic [AW-1:0] a);
      logic [XLEN-1:0] v;
      if (a == 0) return '0;
      v = m_regs[a];
      for (int w = 0; w < NW; w++) if (we[w] && wa[w] == a) v = wd[w];
      return v;
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
      for (int w = 0; w < NW; w++) if (we[w] && wa[w] == a) return 1'b0;
      return m_busy[a];
   endfunction

   typedef struct {
      int          idx;
      logic [31:0] data;
      bit          last;
   } beat_t;
   beat_t beats[$];
   bit    rec_en = 1'b0;

   always @(negedge clock) begin
      for (int p = 0; p < NR; p++) begin
         chk($sformatf("model_rdata%0d", p), readData[p*XLEN +: XLEN], exp_read(ra[p]));
         chk($sformatf("model_rbusy%0d", p), {31'b0, readBusy[p]}, {31'b0, exp_busy(ra[p])});
      end
      chk("model_dvalid", {31'b0, dumpValid}, {31'b0, m_dump_active});
      chk("model_dlast", {31'b0, dumpLast}, {31'b0, (m_dump_active && m_beat == DEPTH - 1)});
      if (m_dump_active) begin
         chk("model_dindex", {27'b0, dumpIndex}, m_beat);
         chk("model_ddata", dumpData, m_regs[m_beat]);
      end
      if (rec_en && dumpValid && dumpReady) begin
         beats.push_back('{idx: int'(dumpIndex), data: dumpData, last: dumpLast});
         $display("beat index=%0d data=0x%08h last=%0b", dumpIndex, dumpData, dumpLast);
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      we             = '0;
      reserveEnable  = 1'b0;
      reserveAddress = '0;
      dumpStart      = 1'b0;
      for (int w = 0; w < NW; w++) begin
         wa[w] = '0;
         wd[w] = '0;
      end
   endtask

   initial begin
      ra[0] = '0; ra[1] = '0; dumpReady = 1'b0;
      idle_inputs();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;

      // Reset state at addresses 0, 5, 31
      ra[0] = 5'd0; ra[1] = 5'd5; #2;
      chk("rst_rdata_a0", readData[31:0], 32'h0);
      chk("rst_rdata_a5", readData[63:32], 32'h0);
      chk("rst_rbusy", {30'b0, readBusy}, 32'h0);
      ra[0] = 5'd31; #1;
      chk("rst_rdata_a31", readData[31:0], 32'h0);
      chk("rst_dvalid", {31'b0, dumpValid}, 32'h0);
      chk("rst_dindex", {27'b0, dumpIndex}, 32'h0);
      chk("rst_ddata", dumpData, 32'h0);
      chk("rst_dlast", {31'b0, dumpLast}, 32'h0);
      $display("txn reset state checked");

      // Bypass then array read of reg 5
      step();
      we[0] = 1'b1; wa[0] = 5'd5; wd[0] = 32'hDEADBEEF; ra[0] = 5'd5; #2;
      chk("bypass_r5", readData[31:0], 32'hDEADBEEF);
      step(); idle_inputs(); #2;
      chk("array_r5", readData[31:0], 32'hDEADBEEF);
      $display("txn write reg5 0xDEADBEEF");

      // Write to reg 0 is dropped
      we[0] = 1'b1; wa[0] = 5'd0; wd[0] = 32'h1234; ra[0] = 5'd0; #2;
      chk("zero_bypass", readData[31:0], 32'h0);
      step(); idle_inputs(); #2;
      chk("zero_array", readData[31:0], 32'h0);
      $display("txn write reg0 dropped");

      // Dual write to reg 7, highest port wins
      we = 2'b11; wa[0] = 5'd7; wa[1] = 5'd7; wd[0] = 32'h11; wd[1] = 32'h22; ra[1] = 5'd7; #2;
      chk("dual_bypass_r7", readData[63:32], 32'h22);
      step(); idle_inputs(); #2;
      chk("dual_array_r7", readData[63:32], 32'h22);
      $display("txn dual write reg7");

      // Scoreboard on reg 9
      ra[0] = 5'd9;
      reserveEnable = 1'b1; reserveAddress = 5'd9; #2;
      chk("busy9_before", {31'b0, readBusy[0]}, 32'h0);
      step(); idle_inputs(); #2;
      chk("busy9_set", {31'b0, readBusy[0]}, 32'h1);
      we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h99; #2;
      chk("busy9_write_bypass", {31'b0, readBusy[0]}, 32'h0);
      step(); idle_inputs(); #2;
      chk("busy9_cleared", {31'b0, readBusy[0]}, 32'h0);
      we[0] = 1'b1; wa[0] = 5'd9; wd[0] = 32'h98;
      reserveEnable = 1'b1; reserveAddress = 5'd9;
      step(); idle_inputs(); #2;
      chk("busy9_reserve_wins", {31'b0, readBusy[0]}, 32'h1);
      $display("txn scoreboard reg9");

      // Load reg i = 3*i, two registers per cycle
      for (int i = 0; i < DEPTH; i += 2) begin
         step();
         we = 2'b11;
         wa[0] = AW'(i);     wd[0] = 32'(i * 3);
         wa[1] = AW'(i + 1); wd[1] = 32'((i + 1) * 3);
      end
      step(); idle_inputs();
      ra[0] = 5'd31; ra[1] = 5'd10; #2;
      chk("load_r31", readData[31:0], 32'd93);
      chk("load_r10", readData[63:32], 32'd30);
      $display("txn loaded reg i = 3*i");

      // Full dump with dumpReady toggling every cycle
      rec_en = 1'b1;
      dumpStart = 1'b1; dumpReady = 1'b0;
      step(); dumpStart = 1'b0; #2;
      chk("dump_first_valid", {31'b0, dumpValid}, 32'h1);
      chk("dump_first_index", {27'b0, dumpIndex}, 32'h0);
      begin
         int cyc = 0;
         while (beats.size() < DEPTH && cyc < 300) begin
            dumpReady = ~dumpReady;
            step();
            cyc++;
         end
      end
      dumpReady = 1'b0;
      rec_en = 1'b0;
      chk("dump_beat_count", beats.size(), DEPTH);
      foreach (beats[k]) begin
         chk($sformatf("dump_idx_%0d", k), beats[k].idx, k);
         chk($sformatf("dump_data_%0d", k), beats[k].data, 32'(k * 3));
         chk($sformatf("dump_last_%0d", k), {31'b0, beats[k].last}, {31'b0, (k == DEPTH - 1)});
      end
      step(); #2;
      chk("dump_done_idle", {31'b0, dumpValid}, 32'h0);
      $display("txn full dump with stalls");

      // Reset in the middle of a dump at index 12
      dumpStart = 1'b1; dumpReady = 1'b1;
      step(); dumpStart = 1'b0;
      begin
         int cyc = 0;
         while (!(dumpValid && dumpIndex == 5'd12) && cyc < 100) begin
            step();
            cyc++;
         end
         chk("reach_index12", {27'b0, dumpIndex}, 32'd12);
      end
      reset = 1'b1; #1;
      chk("midrst_dvalid", {31'b0, dumpValid}, 32'h0);
      chk("midrst_dindex", {27'b0, dumpIndex}, 32'h0);
      chk("midrst_dlast", {31'b0, dumpLast}, 32'h0);
      ra[0] = 5'd31; ra[1] = 5'd5; #1;
      chk("midrst_r31", readData[31:0], 32'h0);
      chk("midrst_r5", readData[63:32], 32'h0);
      step(); reset = 1'b0;
      dumpStart = 1'b1;
      step(); dumpStart = 1'b0; #2;
      chk("restart_valid", {31'b0, dumpValid}, 32'h1);
      chk("restart_index", {27'b0, dumpIndex}, 32'h0);
      chk("restart_data", dumpData, 32'h0);
      $display("txn reset mid-dump and restart");

      repeat (DEPTH + 4) step();
      chk("restart_done", {31'b0, dumpValid}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised successor to the core's integer register file: configurable data width, depth and number of read/write ports, with same-cycle write-to-read bypass on every read port. Adds asynchronous reset clearing of all state, a per-register busy scoreboard for pending producers, and a handshaked debug dump engine that streams the committed register contents. Sits between decode (reads, reserves) and writeback (writes), replacing the single-write, two-read file.

## Interface
- XLEN, 32, data width in bits
- DEPTH, 32, number of registers (power of two, ≥2); AW = $clog2(DEPTH)
- NUM_READ, 2, read ports
- NUM_WRITE, 1, write ports
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes, never busy
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state
- readAddress  in  NUM_READ×AW  read address per port
- readData  out  NUM_READ×XLEN  read data per port (combinational)
- readBusy  out  NUM_READ  register has an outstanding producer
- writeEnable  in  NUM_WRITE  write strobe per port
- writeAddress  in  NUM_WRITE×AW  write address per port
- writeData  in  NUM_WRITE×XLEN  write data per port
- reserveEnable  in  1  mark reserveAddress busy
- reserveAddress  in  AW  register gaining a pending producer
- dumpStart  in  1  request a full register dump
- dumpReady  in  1  consumer accepts current beat
- dumpValid  out  1  beat valid
- dumpIndex  out  AW  register index of beat
- dumpData  out  XLEN  register value of beat
- dumpLast  out  1  final beat (index DEPTH-1)

## Operation
- Reset: every register 0, every busy bit 0, dump FSM IDLE; dumpValid/dumpLast 0, dumpIndex 0, dumpData 0.
- Read: readData[p] = 0 if ZERO_REG and address 0; else data of the highest-index write port with writeEnable and matching address (bypass); else array value.
- Write: each enabled port updates its register at posedge; same-address conflicts resolved highest port index wins; writes to 0 dropped when ZERO_REG.
- Scoreboard: reserveEnable sets busy[reserveAddress]; any enabled write clears busy[writeAddress]. Same address, same cycle: reserve wins (busy stays 1). Reserve to 0 ignored when ZERO_REG.
- readBusy[p] = busy[readAddress[p]] and not matched by an enabled write this cycle; always 0 for register 0 when ZERO_REG.
- Dump FSM states: IDLE → SCAN on dumpStart; SCAN holds index while dumpValid && !dumpReady; advances on handshake; from SCAN at index DEPTH-1 with handshake → IDLE. dumpStart in SCAN ignored.
- dumpData is array value (no bypass) at current index, sampled combinationally each cycle; dumpLast = SCAN && index==DEPTH-1.

## Timing
- Read latency 0 cycles; written value visible via bypass same cycle, via array next cycle.
- busy set/clear take effect at the posedge following the strobe.
- First dump beat: dumpValid high the cycle after dumpStart sampled; back-to-back beats one per cycle with dumpReady held high; full dump DEPTH cycles minimum.
- Reset asserted mid-dump: FSM to IDLE immediately, outputs to reset values; no resume.
- Writes during dump allowed; beat reflects array value on the cycle of handshake.

## Structure
- Package pack: dump_state_t enum {IDLE, SCAN}; default XLEN/DEPTH localparams.
- Sub-module regfile_dump_fsm: owns state, index counter, dumpValid/dumpLast; array read muxed in the top.
- Array, bypass network and scoreboard in multiport_register_file.

## Test plan
- Reset then read all ports at addresses 0, 5, 31 -> readData 0, readBusy 0.
- Write 0xDEADBEEF to reg 5 on port 0, read reg 5 same cycle -> 0xDEADBEEF (bypass); next cycle via array -> 0xDEADBEEF; write to reg 0 -> still reads 0.
- NUM_WRITE=2, both ports write reg 7 (0x11, 0x22) -> reg 7 = 0x22 thereafter.
- Reserve reg 9 -> readBusy 1 next cycle; write reg 9 -> readBusy 0 that cycle, busy 0 after; simultaneous reserve+write reg 9 -> busy stays 1.
- Load reg i = i×3, pulse dumpStart, toggle dumpReady every other cycle -> 32 beats, indices 0..31 in order, data i×3, dumpLast only on index 31, no beat lost while stalled.
- Assert reset at dump index 12 -> dumpValid 0 immediately, all registers read 0, new dumpStart restarts at index 0.
